// File: rtl/dm_sb_bridge_if.sv
// dm_sb_bridge_if: request/grant/rvalid bus bundle used on both sides of the SBA bridge
interface dm_sb_bridge_if #(parameter int BusWidth = 32);
    logic                  req;
    logic                  we;
    logic                  gnt;
    logic                  rvalid;
    logic [BusWidth-1:0]   addr;
    logic [BusWidth-1:0]   wdata;
    logic [BusWidth-1:0]   rdata;
    logic [BusWidth/8-1:0] be;
    modport master (output req, addr, we, wdata, be, input gnt, rvalid, rdata);
    modport slave (input req, addr, we, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/dm_sb_bridge.sv
// dm_sb_bridge: DM SBA master to system bus adapter with in-order tracking, timeout and late-response discard
module dm_sb_bridge #(
    parameter int                     BusWidth       = 32,
    parameter int                     MaxOutstanding = 2,
    parameter int                     TimeoutCycles  = 1024,
    parameter logic [BusWidth-1:0]    ErrData        = BusWidth'(32'hBADC0FFE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dm_sb_bridge_if.slave          dm,
    dm_sb_bridge_if.master         sb,
    input  logic                   err_clr,
    output logic                   err,
    output logic [3:0]             outstanding
);
    localparam int TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TW-1:0] TLast = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [4:0] Max = 5'(MaxOutstanding);
    localparam logic TEn = (TimeoutCycles != 0);

    logic [3:0]    r_cnt;
    logic [3:0]    r_drop;
    logic [TW-1:0] r_timer;
    logic          r_err;
    logic          w_full, w_sb_req, w_accept, w_discard, w_fwd, w_spur, w_fire;

    // Timed-out transactions still occupy a bus slot until their late response drains.
    assign w_full    = ({1'b0, r_cnt} + {1'b0, r_drop}) == Max;
    assign w_sb_req  = rst_n & dm.req & ~w_full;
    assign w_accept  = w_sb_req & sb.gnt;
    assign w_discard = rst_n & sb.rvalid & (r_drop != 4'd0);
    assign w_fwd     = rst_n & sb.rvalid & (r_drop == 4'd0) & (r_cnt != 4'd0);
    assign w_spur    = rst_n & sb.rvalid & (r_drop == 4'd0) & (r_cnt == 4'd0);
    assign w_fire    = rst_n & TEn & ~w_fwd & (r_cnt != 4'd0) & (r_timer == TLast);

    assign sb.req    = w_sb_req;
    assign sb.addr   = dm.addr;
    assign sb.we     = dm.we;
    assign sb.wdata  = dm.wdata;
    assign sb.be     = dm.be;
    assign dm.gnt    = w_accept;
    assign dm.rvalid = w_fwd | w_fire;
    assign dm.rdata  = w_fire ? ErrData : sb.rdata;

    assign err         = r_err;
    assign outstanding = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_drop  <= '0;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + {3'b0, w_accept} - {3'b0, w_fwd | w_fire};
            r_drop  <= r_drop - {3'b0, w_discard} + {3'b0, w_fire};
            r_timer <= (w_fwd | w_fire | (r_cnt == 4'd0)) ? '0 : r_timer + TW'(1);
            r_err   <= w_fire | w_spur | (r_err & ~err_clr);
        end
    end
endmodule
